// File: rtl/instr_sequencer_pkg.sv
// Shared types and defaults for the instruction sequencer: FSM encoding,
// program entry layout and parameter defaults.
package instr_sequencer_pkg;

    localparam int DEPTH_DEF   = 16;
    localparam int TIMEOUT_DEF = 255;
    localparam int OP_W        = 8;
    localparam int ENTRY_W     = 3 * OP_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic [OP_W-1:0] instr;
        logic            mode;
    } entry_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// CPU-facing issue/result channel; the sequencer is master, the CPU is slave.
interface instr_sequencer_if;
    import instr_sequencer_pkg::*;

    logic            cpu_valid;
    logic            cpu_ready;
    logic [OP_W-1:0] cpu_a;
    logic [OP_W-1:0] cpu_b;
    logic [OP_W-1:0] cpu_instr;
    logic            cpu_mode;
    logic            res_valid;
    logic [OP_W-1:0] res_data;

    modport master (
        output cpu_valid, cpu_a, cpu_b, cpu_instr, cpu_mode,
        input  cpu_ready, res_valid, res_data
    );

    modport slave (
        input  cpu_valid, cpu_a, cpu_b, cpu_instr, cpu_mode,
        output cpu_ready, res_valid, res_data
    );

endinterface

// File: rtl/instr_sequencer_seq_entry_ram.sv
// Program store: DEPTH x 25-bit register file, one write port, one
// asynchronous read port, cleared by reset.
module seq_entry_ram
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    entry_t mem_q [DEPTH];
    entry_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    // NOTE: the store must read back as zero after reset, so it is built from
    // resettable flops rather than an unreset RAM array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Runs a loaded program of up to DEPTH entries through a CPU one entry at a
// time, collecting each result; a missing result aborts the run with err.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [OP_W-1:0]          load_a,
    input  logic [OP_W-1:0]          load_b,
    input  logic [OP_W-1:0]          load_instr,
    input  logic                     load_mode,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   count,
    instr_sequencer_if.master        cpu,
    input  logic [$clog2(DEPTH)-1:0] res_rd_addr,
    output logic [OP_W-1:0]          res_rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int            AW      = $clog2(DEPTH);
    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   DEPTH_N = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [AW:0]       n_q, n_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              err_q, err_d;
    logic [OP_W-1:0]   res_q [DEPTH];
    logic [OP_W-1:0]   res_d [DEPTH];
    logic              ram_we;
    entry_t            load_entry, cur_entry, issue_entry;

    assign load_entry = '{a: load_a, b: load_b, instr: load_instr, mode: load_mode};

    seq_entry_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (load_addr),
        .wdata (load_entry),
        .raddr (pc_q),
        .rdata (cur_entry)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        n_d     = n_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        res_d   = res_q;
        ram_we  = load_en && (state_q == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d  = (count > DEPTH_N) ? DEPTH_N : count;
                    pc_d = '0;
                    if (n_d == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_ISSUE;
                        err_d   = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                if (cpu.cpu_ready) begin
                    state_d = ST_WAIT;
                    tmo_d   = '0;
                end
            end
            ST_WAIT: begin
                // A result arriving on the timeout cycle still counts.
                if (cpu.res_valid) begin
                    res_d[pc_q] = cpu.res_data;
                    if ({1'b0, pc_q} == n_q - 1'b1) begin
                        state_d = ST_FIN;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end else if (tmo_q == TMO_END) begin
                    err_d       = 1'b1;
                    res_d[pc_q] = '0;
                    state_d     = ST_FIN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            n_q     <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) res_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            n_q     <= n_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            res_q   <= res_d;
        end
    end

    // Outputs decode straight from state so reset clears them without a clock.
    assign cpu.cpu_valid = (state_q == ST_ISSUE);
    assign issue_entry   = cpu.cpu_valid ? cur_entry : '0;
    assign cpu.cpu_a     = issue_entry.a;
    assign cpu.cpu_b     = issue_entry.b;
    assign cpu.cpu_instr = issue_entry.instr;
    assign cpu.cpu_mode  = issue_entry.mode;

    assign res_rd_data = res_q[res_rd_addr];
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);
    assign err         = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: single issue, stalled multi-issue,
// empty run, timeout, ignored mid-run controls and mid-run reset.
module tb_instr_sequencer;

    logic       clk;
    logic       rst_n;
    logic       load_en;
    logic [3:0] load_addr;
    logic [7:0] load_a, load_b, load_instr;
    logic       load_mode;
    logic       start;
    logic [4:0] count;
    logic [3:0] res_rd_addr;
    logic [7:0] res_rd_data;
    logic       busy, done, err;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    int done_pulses  = 0;
    int v0, d0;

    instr_sequencer_if cpu_if ();

    instr_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_a      (load_a),
        .load_b      (load_b),
        .load_instr  (load_instr),
        .load_mode   (load_mode),
        .start       (start),
        .count       (count),
        .cpu         (cpu_if.master),
        .res_rd_addr (res_rd_addr),
        .res_rd_data (res_rd_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cpu_if.cpu_valid) valid_cycles++;
        if (done) done_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] cpu_fields();
        return {cpu_if.cpu_a, cpu_if.cpu_b, cpu_if.cpu_instr, cpu_if.cpu_mode};
    endfunction

    task automatic load_entry(input logic [3:0] addr, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] instr, input logic mode);
        load_en = 1'b1; load_addr = addr;
        load_a = a; load_b = b; load_instr = instr; load_mode = mode;
        tick();
        load_en = 1'b0;
    endtask

    task automatic read_result(input logic [3:0] addr, input logic [7:0] exp, input string tag);
        res_rd_addr = addr;
        #1;
        check(tag, res_rd_data, exp);
    endtask

    initial begin
        rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_a = '0; load_b = '0;
        load_instr = '0; load_mode = 1'b0; start = 1'b0; count = '0; res_rd_addr = '0;
        cpu_if.cpu_ready = 1'b0; cpu_if.res_valid = 1'b0; cpu_if.res_data = '0;

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valid", cpu_if.cpu_valid, 0);
        check("rst_fields", cpu_fields(), 0);
        read_result(4'd0, 8'h00, "rst_res0");
        rst_n = 1'b1;
        tick();

        // Single entry, immediate accept, result three cycles later
        load_entry(4'd0, 8'h0F, 8'h03, 8'h28, 1'b0);
        v0 = valid_cycles; d0 = done_pulses;
        cpu_if.cpu_ready = 1'b1;
        start = 1'b1; count = 5'd1;
        tick();
        start = 1'b0;
        check("t1_valid", cpu_if.cpu_valid, 1);
        check("t1_fields", cpu_fields(), {8'h0F, 8'h03, 8'h28, 1'b0});
        check("t1_busy", busy, 1);
        tick();
        check("t1_wait_valid", cpu_if.cpu_valid, 0);
        check("t1_wait_fields", cpu_fields(), 0);
        tick();
        tick();
        cpu_if.res_valid = 1'b1; cpu_if.res_data = 8'h12;
        tick();
        cpu_if.res_valid = 1'b0;
        check("t1_done", done, 1);
        tick();
        check("t1_done_low", done, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_err", err, 0);
        check("t1_valid_cycles", valid_cycles - v0, 1);
        check("t1_done_pulses", done_pulses - d0, 1);
        read_result(4'd0, 8'h12, "t1_res0");

        // Four entries, each issue stalled two cycles
        for (int i = 0; i < 4; i++)
            load_entry(4'(i), 8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), i[0]);
        d0 = done_pulses;
        cpu_if.cpu_ready = 1'b0;
        start = 1'b1; count = 5'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 3; s++) begin
                check($sformatf("t2_fields_%0d_%0d", i, s), cpu_fields(),
                      {8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), i[0]});
                if (s < 2) tick();
            end
            cpu_if.cpu_ready = 1'b1;
            tick();
            cpu_if.cpu_ready = 1'b0;
            check($sformatf("t2_wait_valid_%0d", i), cpu_if.cpu_valid, 0);
            cpu_if.res_valid = 1'b1; cpu_if.res_data = 8'(8'hA0 + i);
            tick();
            cpu_if.res_valid = 1'b0;
        end
        check("t2_done", done, 1);
        tick();
        check("t2_idle", busy, 0);
        check("t2_done_pulses", done_pulses - d0, 1);
        for (int i = 0; i < 4; i++)
            read_result(4'(i), 8'(8'hA0 + i), $sformatf("t2_res%0d", i));

        // Empty run
        v0 = valid_cycles; d0 = done_pulses;
        start = 1'b1; count = 5'd0;
        tick();
        start = 1'b0;
        check("t3_busy", busy, 1);
        check("t3_done", done, 1);
        check("t3_valid", cpu_if.cpu_valid, 0);
        tick();
        check("t3_busy_low", busy, 0);
        check("t3_done_low", done, 0);
        check("t3_valid_cycles", valid_cycles - v0, 0);
        check("t3_done_pulses", done_pulses - d0, 1);

        // Timeout on the second entry
        cpu_if.cpu_ready = 1'b1;
        start = 1'b1; count = 5'd2;
        tick();
        start = 1'b0;
        tick();
        cpu_if.res_valid = 1'b1; cpu_if.res_data = 8'h55;
        tick();
        cpu_if.res_valid = 1'b0;
        tick();
        repeat (254) tick();
        check("t4_err_early", err, 0);
        check("t4_busy_early", busy, 1);
        tick();
        check("t4_err", err, 1);
        check("t4_done", done, 1);
        tick();
        check("t4_err_sticky", err, 1);
        read_result(4'd0, 8'h55, "t4_res0");
        read_result(4'd1, 8'h00, "t4_res1");
        start = 1'b1; count = 5'd1;
        tick();
        start = 1'b0;
        check("t4_err_clear", err, 0);
        tick();
        cpu_if.res_valid = 1'b1; cpu_if.res_data = 8'h66;
        tick();
        cpu_if.res_valid = 1'b0;
        tick();

        // start and load_en mid-run are ignored
        d0 = done_pulses;
        start = 1'b1; count = 5'd2;
        tick();
        start = 1'b0;
        tick();
        load_en = 1'b1; load_addr = 4'd1; load_a = 8'hFF; load_b = 8'hFF;
        load_instr = 8'hFF; load_mode = 1'b0;
        start = 1'b1; count = 5'd5;
        tick();
        load_en = 1'b0; start = 1'b0;
        check("t5_still_wait", cpu_if.cpu_valid, 0);
        cpu_if.res_valid = 1'b1; cpu_if.res_data = 8'h77;
        tick();
        cpu_if.res_valid = 1'b0;
        check("t5_entry1", cpu_fields(), {8'h11, 8'h21, 8'h31, 1'b1});
        tick();
        cpu_if.res_valid = 1'b1; cpu_if.res_data = 8'h78;
        tick();
        cpu_if.res_valid = 1'b0;
        check("t5_done", done, 1);
        tick();
        check("t5_idle", busy, 0);
        check("t5_done_pulses", done_pulses - d0, 1);
        read_result(4'd1, 8'h78, "t5_res1");

        // Reset during WAIT
        d0 = done_pulses;
        start = 1'b1; count = 5'd1;
        tick();
        start = 1'b0;
        tick();
        tick();
        read_result(4'd0, 8'h77, "t6_res0_pre");
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_valid", cpu_if.cpu_valid, 0);
        check("t6_done", done, 0);
        check("t6_fields", cpu_fields(), 0);
        read_result(4'd0, 8'h00, "t6_res0");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_no_done", done_pulses - d0, 0);

        // Load and start in the same cycle after reset
        load_en = 1'b1; load_addr = 4'd0; load_a = 8'h5A; load_b = 8'hA5;
        load_instr = 8'h3C; load_mode = 1'b1;
        start = 1'b1; count = 5'd1;
        tick();
        load_en = 1'b0; start = 1'b0;
        check("t7_fields", cpu_fields(), {8'h5A, 8'hA5, 8'h3C, 1'b1});
        tick();
        cpu_if.res_valid = 1'b1; cpu_if.res_data = 8'h99;
        tick();
        cpu_if.res_valid = 1'b0;
        check("t7_done", done, 1);
        tick();
        read_result(4'd0, 8'h99, "t7_res0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
